// File: rtl/hp48_bus_ctrl.sv
// Saturn bus initiator: one core request becomes a strobe-paced command sequence on the bus.
// Optional BUS_PTR_CACHE_EN: skip LOAD_PC/LOAD_DP when the shadow pointer already matches.

`ifndef BUSCMD_NOP
`define BUSCMD_NOP       4'h0
`define BUSCMD_PC_READ   4'h1
`define BUSCMD_DP_READ   4'h2
`define BUSCMD_PC_WRITE  4'h3
`define BUSCMD_DP_WRITE  4'h4
`define BUSCMD_LOAD_PC   4'h5
`define BUSCMD_LOAD_DP   4'h6
`define BUSCMD_CONFIGURE 4'h7
`define BUSCMD_RESET     4'h8
`endif

module hp48_bus_ctrl #(
  parameter int unsigned MAX_NIB = 16
) (
  input  logic                 strobe,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic                 req_use_dp,
  input  logic [19:0]          req_addr,
  input  logic [3:0]           req_len,
  input  logic [4*MAX_NIB-1:0] wr_data,
  output logic [4*MAX_NIB-1:0] rd_data,
  output logic                 done,
  output logic                 done_error,
  output logic [3:0]           bus_command,
  output logic [19:0]          bus_address,
  output logic [3:0]           bus_nibble_out,
  input  logic [3:0]           bus_nibble_in,
  input  logic                 bus_active
);

  localparam int unsigned DW = 4 * MAX_NIB;

  typedef enum logic [2:0] {StIdle, StLoad, StData, StDrain, StCmd} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            dp_q, dp_d;
  logic [19:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [DW-1:0]   wr_q, wr_d;
  logic [3:0]      idx_q, idx_d;
  // dv_*: a data command is on the bus this cycle; cv_*: its read nibble is on bus_nibble_in
  logic            dv_q, dv_d, dv_last_q, dv_last_d;
  logic [3:0]      dv_idx_q, dv_idx_d;
  logic            cv_q, cv_d, cv_last_q, cv_last_d;
  logic [3:0]      cv_idx_q, cv_idx_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic            done_q, done_d, err_q, err_d;
  logic [3:0]      cmd_q, cmd_d, nib_q, nib_d;
  logic [19:0]     baddr_q, baddr_d;
  logic            accept, hit, is_read;

  assign accept  = req_valid && (state_q == StIdle);
  assign is_read = (op_q == 2'b00);

`ifdef BUS_PTR_CACHE_EN
  logic [19:0] pc_sh_q, pc_sh_d, dp_sh_q, dp_sh_d;
  logic        pc_ok_q, pc_ok_d, dp_ok_q, dp_ok_d;

  always_comb begin
    hit = 1'b0;
    if (!req_op[1]) begin
      hit = req_use_dp ? (dp_ok_q && (dp_sh_q == req_addr))
                       : (pc_ok_q && (pc_sh_q == req_addr));
    end
  end

  // Shadows track where the responders' pointers will sit after each issued command.
  always_comb begin
    pc_sh_d = pc_sh_q;
    dp_sh_d = dp_sh_q;
    pc_ok_d = pc_ok_q;
    dp_ok_d = dp_ok_q;
    if (state_q == StLoad) begin
      if (dp_q) begin
        dp_sh_d = addr_q;
        dp_ok_d = 1'b1;
      end else begin
        pc_sh_d = addr_q;
        pc_ok_d = 1'b1;
      end
    end else if (state_q == StData) begin
      if (dp_q) dp_sh_d = dp_sh_q + 20'd1;
      else      pc_sh_d = pc_sh_q + 20'd1;
    end
  end

  always_ff @(posedge strobe) begin
    if (reset) begin
      pc_sh_q <= '0;
      dp_sh_q <= '0;
      pc_ok_q <= 1'b0;
      dp_ok_q <= 1'b0;
    end else begin
      pc_sh_q <= pc_sh_d;
      dp_sh_q <= dp_sh_d;
      pc_ok_q <= pc_ok_d;
      dp_ok_q <= dp_ok_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge strobe) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dp_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wr_q      <= '0;
      idx_q     <= '0;
      dv_q      <= 1'b0;
      dv_last_q <= 1'b0;
      dv_idx_q  <= '0;
      cv_q      <= 1'b0;
      cv_last_q <= 1'b0;
      cv_idx_q  <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cmd_q     <= `BUSCMD_NOP;
      baddr_q   <= '0;
      nib_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dp_q      <= dp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      dv_q      <= dv_d;
      dv_last_q <= dv_last_d;
      dv_idx_q  <= dv_idx_d;
      cv_q      <= cv_d;
      cv_last_q <= cv_last_d;
      cv_idx_q  <= cv_idx_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      baddr_q   <= baddr_d;
      nib_q     <= nib_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op[1]) state_d = StCmd;
          else           state_d = hit ? StData : StLoad;
        end
      end
      StLoad:  state_d = StData;
      StData:  if (idx_q == len_q) state_d = StDrain;
      StDrain: if (cv_q && cv_last_q) state_d = StIdle;
      StCmd:   if (idx_q == 4'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    op_d      = op_q;
    dp_d      = dp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    err_d     = err_q;
    baddr_d   = baddr_q;
    cmd_d     = `BUSCMD_NOP;
    nib_d     = 4'h0;
    done_d    = 1'b0;
    dv_d      = 1'b0;
    dv_last_d = 1'b0;
    dv_idx_d  = 4'h0;
    cv_d      = dv_q;
    cv_last_d = dv_last_q;
    cv_idx_d  = dv_idx_q;

    if (dv_q) err_d = err_q | ~bus_active;
    if (cv_q && is_read) rd_d[{cv_idx_q, 2'b00} +: 4] = bus_nibble_in;

    if (accept) begin
      op_d   = req_op;
      dp_d   = req_use_dp;
      addr_d = req_addr;
      len_d  = req_len;
      wr_d   = wr_data;
      idx_d  = 4'h0;
      rd_d   = '0;
      err_d  = 1'b0;
    end

    unique case (state_q)
      StLoad: begin
        cmd_d   = dp_q ? `BUSCMD_LOAD_DP : `BUSCMD_LOAD_PC;
        baddr_d = addr_q;
      end
      StData: begin
        unique case ({op_q[0], dp_q})
          2'b00:   cmd_d = `BUSCMD_PC_READ;
          2'b01:   cmd_d = `BUSCMD_DP_READ;
          2'b10:   cmd_d = `BUSCMD_PC_WRITE;
          default: cmd_d = `BUSCMD_DP_WRITE;
        endcase
        if (op_q[0]) nib_d = wr_q[{idx_q, 2'b00} +: 4];
        dv_d      = 1'b1;
        dv_last_d = (idx_q == len_q);
        dv_idx_d  = idx_q;
        idx_d     = idx_q + 4'd1;
      end
      StDrain: begin
        if (cv_q && cv_last_q) done_d = 1'b1;
      end
      StCmd: begin
        if (idx_q == 4'd0) begin
          cmd_d = op_q[0] ? `BUSCMD_RESET : `BUSCMD_CONFIGURE;
          if (!op_q[0]) baddr_d = addr_q;
          idx_d = 4'd1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready      = (state_q == StIdle);
  assign rd_data        = rd_q;
  assign done           = done_q;
  assign done_error     = err_q;
  assign bus_command    = cmd_q;
  assign bus_address    = baddr_q;
  assign bus_nibble_out = nib_q;

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Bench for hp48_bus_ctrl: a small RAM responder model plus a scoreboard of expected bus commands.
// Expectations for the pointer cache follow BUS_PTR_CACHE_EN when it is defined for the build.

`ifndef BUSCMD_NOP
`define BUSCMD_NOP       4'h0
`define BUSCMD_PC_READ   4'h1
`define BUSCMD_DP_READ   4'h2
`define BUSCMD_PC_WRITE  4'h3
`define BUSCMD_DP_WRITE  4'h4
`define BUSCMD_LOAD_PC   4'h5
`define BUSCMD_LOAD_DP   4'h6
`define BUSCMD_CONFIGURE 4'h7
`define BUSCMD_RESET     4'h8
`endif

module tb_hp48_bus_ctrl;

  logic        strobe, reset, req_valid, req_ready, req_use_dp;
  logic [1:0]  req_op;
  logic [19:0] req_addr, bus_address;
  logic [3:0]  req_len, bus_command, bus_nibble_out, bus_nibble_in;
  logic [63:0] wr_data, rd_data;
  logic        done, done_error, bus_active;

  hp48_bus_ctrl #(.MAX_NIB(16)) dut (
    .strobe(strobe), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_use_dp(req_use_dp), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .done_error(done_error),
    .bus_command(bus_command), .bus_address(bus_address), .bus_nibble_out(bus_nibble_out),
    .bus_nibble_in(bus_nibble_in), .bus_active(bus_active)
  );

  initial strobe = 1'b0;
  always #5 strobe = ~strobe;

  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge strobe) cyc <= cyc + 1;

  // RAM responder: first CONFIGURE gives the address mask, second the base
  logic        mrst, daisy_in, daisy_out, configured, cfg_first;
  logic [19:0] rpc, rdp, cfg_mask, cfg_base, cur_ptr;
  logic [3:0]  rnib;
  logic [3:0]  mem [0:255];
  logic        is_data;

  assign daisy_in  = 1'b1;
  assign daisy_out = configured;

  function automatic logic mapped(input logic [19:0] a);
    return configured && ((a & cfg_mask) == cfg_base);
  endfunction

  always_comb begin
    is_data = (bus_command == `BUSCMD_PC_READ) || (bus_command == `BUSCMD_DP_READ) ||
              (bus_command == `BUSCMD_PC_WRITE) || (bus_command == `BUSCMD_DP_WRITE);
    cur_ptr = ((bus_command == `BUSCMD_DP_READ) || (bus_command == `BUSCMD_DP_WRITE)) ? rdp : rpc;
  end
  assign bus_active    = is_data && mapped(cur_ptr);
  assign bus_nibble_in = rnib;

  always @(posedge strobe) begin
    if (mrst) begin
      configured <= 1'b0;
      cfg_first  <= 1'b1;
      cfg_mask   <= '0;
      cfg_base   <= '0;
      rpc        <= '0;
      rdp        <= '0;
      rnib       <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
    end else begin
      rnib <= 4'h0;
      case (bus_command)
        `BUSCMD_LOAD_PC: rpc <= bus_address;
        `BUSCMD_LOAD_DP: rdp <= bus_address;
        `BUSCMD_CONFIGURE: begin
          if (daisy_in && !configured) begin
            if (cfg_first) begin
              cfg_mask  <= bus_address;
              cfg_first <= 1'b0;
            end else begin
              cfg_base   <= bus_address;
              configured <= 1'b1;
            end
          end
        end
        `BUSCMD_PC_READ: begin
          if (mapped(rpc)) rnib <= mem[rpc[7:0]];
          rpc <= rpc + 20'd1;
        end
        `BUSCMD_DP_READ: begin
          if (mapped(rdp)) rnib <= mem[rdp[7:0]];
          rdp <= rdp + 20'd1;
        end
        `BUSCMD_PC_WRITE: begin
          if (mapped(rpc)) mem[rpc[7:0]] <= bus_nibble_out;
          rpc <= rpc + 20'd1;
        end
        `BUSCMD_DP_WRITE: begin
          if (mapped(rdp)) mem[rdp[7:0]] <= bus_nibble_out;
          rdp <= rdp + 20'd1;
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [3:0]  nib;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  logic mon_en = 1'b0;

  function automatic void exp_ev(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n,
                                 input int cy);
    ev_t e;
    e.cmd = c; e.addr = a; e.nib = n; e.cyc = cy;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_reads(input logic [3:0] c, input int first, input int count);
    for (int i = 0; i < count; i++) exp_ev(c, 20'h0, 4'h0, first + i);
  endfunction

  task automatic bus_monitor();
    ev_t  e;
    logic bad;
    forever begin
      @(negedge strobe);
      if (mon_en && bus_command !== `BUSCMD_NOP) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_cmd_unexpected: got cmd=%h addr=%h at cycle %0d, required NOP",
                   bus_command, bus_address, cyc - acc_cyc);
        end else begin
          e = exp_q.pop_front();
          bad = (bus_command !== e.cmd) || ((cyc - acc_cyc) != e.cyc);
          if ((e.cmd == `BUSCMD_LOAD_PC || e.cmd == `BUSCMD_LOAD_DP ||
               e.cmd == `BUSCMD_CONFIGURE) && bus_address !== e.addr) bad = 1'b1;
          if ((e.cmd == `BUSCMD_PC_WRITE || e.cmd == `BUSCMD_DP_WRITE) &&
              bus_nibble_out !== e.nib) bad = 1'b1;
          if (bad)
            $display("FAIL bus_cmd: got cmd=%h addr=%h nib=%h cycle=%0d, required cmd=%h addr=%h nib=%h cycle=%0d",
                     bus_command, bus_address, bus_nibble_out, cyc - acc_cyc,
                     e.cmd, e.addr, e.nib, e.cyc);
          if (bad) n_fail++;
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic dp, input logic [19:0] a,
                       input logic [3:0] len, input logic [63:0] wd);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge strobe);
      n++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b, required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_use_dp = dp; req_addr = a; req_len = len; wr_data = wd;
    @(negedge strobe);
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int off);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge strobe);
      n++;
    end
    off = (done === 1'b1) ? cyc - acc_cyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge strobe);
    n_checks += 7;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", req_ready); end
    if (bus_command !== `BUSCMD_NOP) begin n_fail++; $display("FAIL rst_cmd: got %h, required 0", bus_command); end
    if (bus_address !== 20'h0) begin n_fail++; $display("FAIL rst_addr: got %h, required 0", bus_address); end
    if (bus_nibble_out !== 4'h0) begin n_fail++; $display("FAIL rst_nib: got %h, required 0", bus_nibble_out); end
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_rd: got %h, required 0", rd_data); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
    if (done_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", done_error); end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_config();
    int off;
    exp_ev(`BUSCMD_CONFIGURE, 20'hC0000, 4'h0, 1);
    issue(2'b10, 1'b0, 20'hC0000, 4'h0, 64'h0);
    wait_done(off);
    n_checks++;
    if (off != 2 || done_error !== 1'b0) begin
      n_fail++; $display("FAIL cfg1_done: cycle=%0d err=%b, required cycle=2 err=0", off, done_error);
    end
    exp_ev(`BUSCMD_CONFIGURE, 20'h80000, 4'h0, 1);
    issue(2'b10, 1'b0, 20'h80000, 4'h0, 64'h0);
    wait_done(off);
    n_checks++;
    if (off != 2 || done_error !== 1'b0) begin
      n_fail++; $display("FAIL cfg2_done: cycle=%0d err=%b, required cycle=2 err=0", off, done_error);
    end
    n_checks++;
    if (daisy_out !== 1'b1) begin n_fail++; $display("FAIL cfg_daisy: got %b, required 1", daisy_out); end
  endtask

  task automatic test_unmapped();
    int off;
    exp_ev(`BUSCMD_LOAD_PC, 20'h00100, 4'h0, 1);
    exp_reads(`BUSCMD_PC_READ, 2, 1);
    issue(2'b00, 1'b0, 20'h00100, 4'h0, 64'h0);
    wait_done(off);
    n_checks++;
    if (off != 4 || done_error !== 1'b1) begin
      n_fail++; $display("FAIL unmapped: cycle=%0d err=%b, required cycle=4 err=1", off, done_error);
    end
  endtask

  task automatic test_write();
    int off;
    exp_ev(`BUSCMD_LOAD_DP, 20'h80010, 4'h0, 1);
    for (int i = 0; i < 4; i++) exp_ev(`BUSCMD_DP_WRITE, 20'h0, 4'(i + 1), 2 + i);
    issue(2'b01, 1'b1, 20'h80010, 4'h3, 64'h4321);
    wait_done(off);
    n_checks += 2;
    if (off != 7 || done_error !== 1'b0) begin
      n_fail++; $display("FAIL write_done: cycle=%0d err=%b, required cycle=7 err=0", off, done_error);
    end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready: got %b, required 1", req_ready); end
  endtask

  // Issued in the done cycle of the preceding write
  task automatic test_back_to_back();
    int off;
    exp_ev(`BUSCMD_LOAD_PC, 20'h80014, 4'h0, 1);
    exp_ev(`BUSCMD_PC_WRITE, 20'h0, 4'hA, 2);
    exp_ev(`BUSCMD_PC_WRITE, 20'h0, 4'hB, 3);
    exp_ev(`BUSCMD_PC_WRITE, 20'h0, 4'hC, 4);
    exp_ev(`BUSCMD_PC_WRITE, 20'h0, 4'hD, 5);
    issue(2'b01, 1'b0, 20'h80014, 4'h3, 64'hDCBA);
    wait_done(off);
    n_checks++;
    if (off != 7 || done_error !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: cycle=%0d err=%b, required cycle=7 err=0", off, done_error);
    end
  endtask

  task automatic test_read(input logic [19:0] a, input logic [3:0] len, input logic [63:0] exp_rd,
                           input int exp_off, input logic expect_load);
    int off;
    int first;
    first = expect_load ? 2 : 1;
    if (expect_load) exp_ev(`BUSCMD_LOAD_PC, a, 4'h0, 1);
    exp_reads(`BUSCMD_PC_READ, first, int'(len) + 1);
    issue(2'b00, 1'b0, a, len, 64'h0);
    wait_done(off);
    n_checks += 2;
    if (off != exp_off || done_error !== 1'b0) begin
      n_fail++; $display("FAIL read_done @%h: cycle=%0d err=%b, required cycle=%0d err=0",
                         a, off, done_error, exp_off);
    end
    if (rd_data !== exp_rd) begin
      n_fail++; $display("FAIL read_data @%h: got %h, required %h", a, rd_data, exp_rd);
    end
  endtask

  task automatic test_cache();
`ifdef BUS_PTR_CACHE_EN
    test_read(20'h80014, 4'h3, 64'hDCBA, 6, 1'b0);
`else
    test_read(20'h80014, 4'h3, 64'hDCBA, 7, 1'b1);
`endif
  endtask

  task automatic test_bus_reset();
    int off;
    exp_ev(`BUSCMD_RESET, 20'h0, 4'h0, 1);
    issue(2'b11, 1'b0, 20'h0, 4'h0, 64'h0);
    wait_done(off);
    n_checks++;
    if (off != 2 || done_error !== 1'b0) begin
      n_fail++; $display("FAIL busrst_done: cycle=%0d err=%b, required cycle=2 err=0", off, done_error);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    exp_ev(`BUSCMD_LOAD_DP, 20'h80020, 4'h0, 1);
    exp_ev(`BUSCMD_DP_WRITE, 20'h0, 4'h0, 2);
    exp_ev(`BUSCMD_DP_WRITE, 20'h0, 4'h1, 3);
    issue(2'b01, 1'b1, 20'h80020, 4'hF, 64'hFEDC_BA98_7654_3210);
    repeat (3) @(negedge strobe);
    reset = 1'b1;
    @(negedge strobe);
    n_checks += 3;
    if (bus_command !== `BUSCMD_NOP) begin n_fail++; $display("FAIL midrst_cmd: got %h, required 0", bus_command); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", req_ready); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, required 0", done); end
    reset = 1'b0;
    repeat (20) begin
      @(negedge strobe);
      if (done === 1'b1) seen++;
    end
    n_checks += 2;
    if (seen != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d done pulses, required 0", seen); end
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_cmds: %0d expected commands never seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    mrst = 1'b1; reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_use_dp = 1'b0;
    req_addr = '0; req_len = '0; wr_data = '0;
    fork
      bus_monitor();
    join_none
    repeat (2) @(negedge strobe);
    mrst = 1'b0;
    test_reset();
    test_config();
    test_unmapped();
    test_write();
    test_back_to_back();
    test_read(20'h80010, 4'h3, 64'h4321, 7, 1'b1);
    test_cache();
    test_bus_reset();
    test_mid_reset();
    // Shadow pointers were dropped by the reset, so LOAD_PC must reappear
    test_read(20'h80014, 4'h3, 64'hDCBA, 7, 1'b1);
    test_read(20'h80010, 4'hF, 64'h0000_0000_DCBA_4321, 19, 1'b1);
    test_read(20'h80014, 4'h0, 64'hA, 4, 1'b1);
    repeat (4) @(negedge strobe);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_cmds: %0d expected commands never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
